// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch vs load/store.
// Data has priority, bounded by a streak limit.
module mem_port_arbiter #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int WAIT_CYCLES     = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic          clk,
  input  logic          Rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner_d
);

  localparam int CW = (WAIT_CYCLES > 1) ?
                      $clog2(WAIT_CYCLES) : 1;
  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [CW-1:0] CNT_INIT =
    CW'(WAIT_CYCLES - 1);
  localparam logic [SW-1:0] STREAK_MAX =
    SW'(MAX_DATA_STREAK);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          own_q, own_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          grant_data;

  // Data wins unless a fetch is waiting and the streak is used up
  assign grant_data = d_req &&
                      (!if_req || (streak_q != STREAK_MAX));

  // Next-state, grant latching and read-data capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    streak_d   = streak_q;
    own_d      = own_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (d_req || if_req) begin
          state_d = S_ACCESS;
          cnt_d   = CNT_INIT;
          own_d   = grant_data;
          if (grant_data) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
            if (streak_q != STREAK_MAX)
              streak_d = streak_q + SW'(1);
          end else begin
            addr_d   = if_addr;
            we_d     = 1'b0;
            streak_d = '0;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          if (!own_q)
            if_rdata_d = mem_rdata;
          else if (!we_q)
            d_rdata_d = mem_rdata;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      streak_q   <= '0;
      own_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      streak_q   <= streak_d;
      own_q      <= own_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en && own_q && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == S_DONE) && !own_q;
  assign d_ack     = (state_q == S_DONE) && own_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner_d   = own_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Directed vectors, WAIT_CYCLES=3, streak limit 4.
module tb_mem_port_arbiter;

  localparam int W  = 3;
  localparam int MX = 4;

  logic        clk = 1'b0;
  logic        Rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        busy;
  logic        owner_d;

  mem_port_arbiter #(
    .AW(32), .DW(32),
    .WAIT_CYCLES(W), .MAX_DATA_STREAK(MX)
  ) dut (
    .clk(clk), .Rst(Rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy), .owner_d(owner_d)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] rdata;
    int          ack_cyc;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nmis = 0;
  int          ack_cnt = 0;
  int          en_run = 0;
  int          last_run = 0;
  logic [31:0] mem_arr [logic [31:0]];

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(bit is_d, bit we,
                              logic [31:0] a,
                              logic [31:0] rd, int ac);
    exp_t e;
    e.is_d = is_d;
    e.we = we;
    e.addr = a;
    e.rdata = rd;
    e.ack_cyc = ac;
    return e;
  endfunction

  // Memory write side
  always @(posedge clk)
    if (Rst && mem_en && mem_we)
      mem_arr[mem_addr] = mem_wdata;

  // Monitor: checks the port, pops on ack, drives read data
  always @(negedge clk) begin
    exp_t e;
    if (mem_en) en_run++;
    else begin
      if (en_run != 0) last_run = en_run;
      en_run = 0;
    end
    if (mem_en && Rst) begin
      if (sb.size() == 0)
        chk("stray_access", 32'(mem_en), 32'd0);
      else begin
        chk("mem_addr", mem_addr, sb[0].addr);
        chk("mem_we", 32'(mem_we), 32'(sb[0].we));
      end
    end
    if (if_ack || d_ack) begin
      ack_cnt++;
      if (sb.size() == 0)
        chk("stray_ack", 32'({if_ack, d_ack}), 32'd0);
      else begin
        e = sb.pop_front();
        chk("ack_owner", 32'({if_ack, d_ack}),
            e.is_d ? 32'd1 : 32'd2);
        chk("owner_d", 32'(owner_d), 32'(e.is_d));
        chk("rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
        chk("access_len", 32'(last_run), 32'(W));
        if (e.ack_cyc >= 0)
          chk("latency", 32'(cyc), 32'(e.ack_cyc));
      end
    end
    if (mem_en && en_run == W && mem_arr.exists(mem_addr))
      mem_rdata = mem_arr[mem_addr];
    else
      mem_rdata = 32'hBAD0_BAD0;
  end

  task automatic do_d(bit we, logic [31:0] a,
                      logic [31:0] wd, bit keep);
    bit got = 1'b0;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_req = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = d_ack;
    end
    chk("d_ack_timeout", 32'(got), 32'd1);
    if (!keep) d_req = 1'b0;
  endtask

  task automatic do_f(logic [31:0] a);
    bit got = 1'b0;
    if_addr = a;
    if_req = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = if_ack;
    end
    chk("if_ack_timeout", 32'(got), 32'd1);
    if_req = 1'b0;
  endtask

  initial begin
    int base;
    bit got;
    mem_arr[32'h100] = 32'hE3A0_1005;
    mem_arr[32'h200] = 32'h0000_0013;
    mem_arr[32'h80]  = 32'h5555_AAAA;
    for (int k = 0; k <= 6; k++)
      mem_arr[32'h300 + 32'(4 * k)] = 32'h1111_0000 + 32'(k);

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ctrl",
        32'({if_ack, d_ack, busy, mem_en, mem_we, owner_d}),
        32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    Rst = 1'b1;

    // Single fetch
    @(negedge clk);
    sb.push_back(mk(0, 0, 32'h100, 32'hE3A0_1005,
                    cyc + W + 1));
    do_f(32'h100);

    // Store then load, d_rdata untouched by the store
    @(negedge clk);
    sb.push_back(mk(1, 1, 32'h40, 32'h0, cyc + W + 1));
    do_d(1, 32'h40, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    sb.push_back(mk(1, 0, 32'h40, 32'hDEAD_BEEF,
                    cyc + W + 1));
    do_d(0, 32'h40, 32'h0, 0);

    // Simultaneous requests: data first, then fetch
    @(negedge clk);
    sb.push_back(mk(1, 0, 32'h300, 32'h1111_0000,
                    cyc + W + 1));
    sb.push_back(mk(0, 0, 32'h200, 32'h0000_0013,
                    cyc + 2 * W + 3));
    fork
      do_d(0, 32'h300, 32'h0, 0);
      do_f(32'h200);
    join

    // Starvation guard: 4 data, 1 fetch, data resumes
    @(negedge clk);
    for (int k = 1; k <= 4; k++)
      sb.push_back(mk(1, 0, 32'h300 + 32'(4 * k),
                      32'h1111_0000 + 32'(k), -1));
    sb.push_back(mk(0, 0, 32'h200, 32'h0000_0013, -1));
    for (int k = 5; k <= 6; k++)
      sb.push_back(mk(1, 0, 32'h300 + 32'(4 * k),
                      32'h1111_0000 + 32'(k), -1));
    fork
      begin
        for (int k = 1; k <= 6; k++)
          do_d(0, 32'h300 + 32'(4 * k), 32'h0, k < 6);
      end
      do_f(32'h200);
    join

    // Input glitch during ACCESS
    @(negedge clk);
    base = ack_cnt;
    sb.push_back(mk(1, 0, 32'h40, 32'hDEAD_BEEF,
                    cyc + W + 1));
    d_we = 1'b0;
    d_addr = 32'h40;
    d_req = 1'b1;
    @(negedge clk);
    d_addr = 32'h80;
    d_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = d_ack;
    end
    chk("glitch_ack_timeout", 32'(got), 32'd1);
    repeat (6) @(negedge clk);
    chk("glitch_one_ack", 32'(ack_cnt - base), 32'd1);
    chk("glitch_idle", 32'(busy), 32'd0);

    // Reset in the second ACCESS cycle
    base = ack_cnt;
    sb.push_back(mk(0, 0, 32'h100, 32'h0, -1));
    if_addr = 32'h100;
    if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_en", 32'(mem_en), 32'd1);
    Rst = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    chk("abort_mem_en", 32'(mem_en), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_if_rdata", if_rdata, 32'd0);
    chk("abort_d_rdata", d_rdata, 32'd0);
    Rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_ack", 32'(ack_cnt - base), 32'd0);
    sb.delete();

    // Fresh fetch after reset
    sb.push_back(mk(0, 0, 32'h100, 32'hE3A0_1005,
                    cyc + W + 1));
    do_f(32'h100);

    for (int i = 0; i < 50 && sb.size() != 0; i++)
      @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nmis);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch path (PC/IR load) and the load/store data path of the multicycle core.
- Each requester uses a req/ack handshake. The block sequences the memory enables over a fixed wait-state count and returns read data in a register.
- Data accesses get priority. A streak limit stops the data path from starving instruction fetch.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- WAIT_CYCLES, 1, memory access cycles per transfer (>=1).
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending (>=1).

Ports:
- clk  in  1  system clock; all state on rising edge
- Rst  in  1  reset, synchronous, active-low
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  AW  fetch address
- if_ack  out  1  one-cycle fetch completion pulse
- if_rdata  out  DW  fetched instruction; valid with if_ack and held after
- d_req  in  1  data request; held until d_ack
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_ack  out  1  one-cycle data completion pulse
- d_rdata  out  DW  load data; valid with d_ack and held after
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid in last ACCESS cycle
- busy  out  1  state != IDLE
- owner_d  out  1  1=data owns port, 0=fetch; meaningful when busy

Behaviour:
- Reset (Rst==0 at clk edge):
  - state=IDLE; streak=0; wait counter=0.
  - All outputs 0, including if_rdata/d_rdata.
  - Reset takes precedence over everything. A reset mid-access aborts it: mem_en=0 from the next cycle and no ack is issued.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE, mem_en=0.
  - d_req only: grant data.
  - if_req only: grant fetch.
  - Both, streak<MAX_DATA_STREAK: grant data.
  - Both, streak==MAX_DATA_STREAK: grant fetch.
  - On grant:
    - Latch owner, address, we and wdata into internal registers.
    - Go to ACCESS with counter=WAIT_CYCLES-1.
    - Streak update: data grant increments streak, saturating at MAX_DATA_STREAK; fetch grant clears it to 0.
- ACCESS:
  - Drive mem_en=1, mem_addr and mem_wdata from the latched registers.
  - mem_we = latched d_we when owner is data, else 0. Fetch never writes.
  - Counter decrements each cycle. When counter==0:
    - Capture mem_rdata into if_rdata or d_rdata (loads and fetches only; stores leave d_rdata unchanged).
    - Go to DONE.
  - Total ACCESS duration is exactly WAIT_CYCLES cycles.
- DONE:
  - mem_en=0, mem_we=0.
  - Assert ack of the owner for exactly one cycle, then go to IDLE.
- Requester obligations:
  - Hold req, address, we and wdata stable until ack is seen.
  - Deassert req in the cycle after ack unless issuing a back-to-back request.
- Latency: req high in IDLE at cycle 0 → ack at cycle WAIT_CYCLES+1. Minimum period between grants is WAIT_CYCLES+2 cycles.
- Boundary conditions:
  - Inputs changing during ACCESS are ignored because the latched copies are used.
  - req dropped before ack: the access still completes and ack still pulses.
  - req dropped while in IDLE before grant: the request is treated as withdrawn.
  - A new request arriving in DONE is considered in the following IDLE cycle.
  - Streak saturation with no fetch pending: data keeps winning and streak stays at MAX.
- mem_addr/mem_wdata hold their last values outside ACCESS. Only mem_en/mem_we qualify them.
- Outputs are registered or decoded directly from state. No combinational path from req to mem_*.

Test Plan:
- Single fetch, WAIT_CYCLES=1: if_req=1, if_addr=0x100, mem_rdata=0xE3A01005 during ACCESS → mem_en=1 at cycle 1 with mem_addr=0x100 and mem_we=0; if_ack=1 at cycle 2 with if_rdata=0xE3A01005; d_ack stays 0.
- Store then load, WAIT_CYCLES=3:
  - Store d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF → mem_en and mem_we high for exactly 3 cycles; d_ack at cycle 4; d_rdata unchanged.
  - Following load from 0x40 → d_rdata=0xDEADBEEF with d_ack.
- Simultaneous requests, streak=0: if_req=d_req=1 → data granted first (owner_d=1); fetch granted in the next IDLE; streak returns to 0 after the fetch.
- Starvation guard, MAX_DATA_STREAK=4: d_req held continuously with back-to-back loads while if_req=1 → exactly 4 d_acks, then an if_ack, then data resumes.
- Reset mid-access: assert Rst=0 during the second ACCESS cycle with WAIT_CYCLES=3 → next cycle mem_en=0, busy=0, no ack ever pulses; after release a fresh if_req completes normally.
- Input glitch: change d_addr from 0x40 to 0x80 and drop d_req during ACCESS → mem_addr stays 0x40; d_ack still pulses once; no second access is started.
